// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART-to-matrix loader: FSM state codes, state_LED
// patterns and the bit-period helper.
package uart_rx_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_BYTE = 3'd1;
  localparam logic [2:0] ST_WRITE     = 3'd2;
  localparam logic [2:0] ST_NEXT      = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  localparam logic [4:0] LED_IDLE      = 5'b10000;
  localparam logic [4:0] LED_WAIT_BYTE = 5'b01000;
  localparam logic [4:0] LED_WRITE     = 5'b00100;
  localparam logic [4:0] LED_NEXT      = 5'b00010;
  localparam logic [4:0] LED_DONE      = 5'b00001;

  localparam logic [2:0] RX_IDLE      = 3'd0;
  localparam logic [2:0] RX_START     = 3'd1;
  localparam logic [2:0] RX_DATA      = 3'd2;
  localparam logic [2:0] RX_STOP      = 3'd3;
  localparam logic [2:0] RX_WAIT_HIGH = 3'd4;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with 2-FF input synchroniser and mid-bit sampling.
// RX_FRAME_CHECK_EN: drop bytes with a low stop bit and pulse frame_err.
module uart_rx_byte
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_meta, rx_s, rx_prev;
  logic [2:0]    rx_state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef RX_FRAME_CHECK_EN
  logic          frame_err_q;
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  // Synchroniser flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
`ifdef RX_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
    end else begin
      byte_valid <= 1'b0;
`ifdef RX_FRAME_CHECK_EN
      frame_err_q <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            cnt      <= HALF;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (cnt == '0) begin
            if (!rx_s) begin
              cnt      <= FULL;
              bit_idx  <= '0;
              rx_state <= RX_DATA;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == '0) begin
            shreg <= {rx_s, shreg[7:1]};
            cnt   <= FULL;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == '0) begin
`ifdef RX_FRAME_CHECK_EN
            if (!rx_s) begin
              frame_err_q <= 1'b1;
              rx_state    <= RX_WAIT_HIGH;
            end else begin
              byte_valid <= 1'b1;
              byte_out   <= shreg;
              rx_state   <= RX_IDLE;
            end
`else
            byte_valid <= 1'b1;
            byte_out   <= shreg;
            rx_state   <= RX_IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_s) rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_to_mem.sv
// Loads ROWS*COLS UART bytes into matrix memory after a load_en rising edge.
// RX_FRAME_CHECK_EN (optional) enables stop-bit checking in the receiver.
//
// state      | meaning
// IDLE       | not loading, count held at 0
// WAIT_BYTE  | waiting for the next received byte
// WRITE      | write strobe for the captured byte
// NEXT       | advance count, decide DONE or WAIT_BYTE
// DONE       | load_done pulse
module uart_rx_to_mem
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int ROWS     = 2,
  parameter int COLS     = 2,
  parameter int ADDR_W   = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_data,
  input  logic                             load_en,
  output logic                             write,
  output logic [ADDR_W-1:0]                write_address,
  output logic [7:0]                       write_value,
  output logic [$clog2(ROWS*COLS+1)-1:0]   values_recv_count,
  output logic [4:0]                       state_LED,
  output logic                             load_done,
  output logic                             frame_err
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = $clog2(ROWS*COLS+1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS*COLS - 1);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic [2:0] state;
  logic       load_meta, load_s, load_prev;
  logic       load_rise;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .byte_valid (byte_valid),
    .byte_out   (rx_byte),
    .frame_err  (frame_err)
  );

  assign load_rise = load_s & ~load_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_meta <= 1'b0;
      load_s    <= 1'b0;
      load_prev <= 1'b0;
    end else begin
      load_meta <= load_en;
      load_s    <= load_meta;
      load_prev <= load_s;
    end
  end

  // Dropping load_en aborts from any active state; issued writes stay in memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= ST_IDLE;
      values_recv_count <= '0;
      write_address     <= '0;
      write_value       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          values_recv_count <= '0;
          if (load_rise) state <= ST_WAIT_BYTE;
        end
        ST_WAIT_BYTE: begin
          if (!load_s) begin
            state             <= ST_IDLE;
            values_recv_count <= '0;
          end else if (byte_valid) begin
            write_address <= ADDR_W'(values_recv_count);
            write_value   <= rx_byte;
            state         <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (!load_s) begin
            state             <= ST_IDLE;
            values_recv_count <= '0;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (!load_s) begin
            state             <= ST_IDLE;
            values_recv_count <= '0;
          end else begin
            values_recv_count <= values_recv_count + 1'b1;
            state <= (values_recv_count == LAST) ? ST_DONE : ST_WAIT_BYTE;
          end
        end
        ST_DONE: begin
          values_recv_count <= '0;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    write     = (state == ST_WRITE);
    load_done = (state == ST_DONE);
    state_LED = LED_IDLE;
    case (state)
      ST_WAIT_BYTE: state_LED = LED_WAIT_BYTE;
      ST_WRITE:     state_LED = LED_WRITE;
      ST_NEXT:      state_LED = LED_NEXT;
      ST_DONE:      state_LED = LED_DONE;
      default:      state_LED = LED_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_to_mem.sv
// Bench for uart_rx_to_mem at 16 clocks per bit, 2x2 matrix, against a
// byte-level model of which frames should land at which address.
module tb_uart_rx_to_mem;

  localparam int CPB = 16;
`ifdef RX_FRAME_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_data = 1'b1;
  logic       load_en = 1'b0;
  logic       write;
  logic [5:0] write_address;
  logic [7:0] write_value;
  logic [2:0] values_recv_count;
  logic [4:0] state_LED;
  logic       load_done;
  logic       frame_err;

  uart_rx_to_mem #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .ROWS(2), .COLS(2), .ADDR_W(6)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data           (rx_data),
    .load_en           (load_en),
    .write             (write),
    .write_address     (write_address),
    .write_value       (write_value),
    .values_recv_count (values_recv_count),
    .state_LED         (state_LED),
    .load_done         (load_done),
    .frame_err         (frame_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Observed activity, sampled on the falling edge
  int   cyc = 0;
  int   wa_q[$], wv_q[$], wc_q[$], done_q[$];
  int   long_write = 0;
  int   ferr_cnt = 0;
  logic prev_write = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (write === 1'b1) begin
      wa_q.push_back(int'(write_address));
      wv_q.push_back(int'(write_value));
      wc_q.push_back(cyc);
      if (prev_write) long_write++;
    end
    prev_write = write;
    if (load_done === 1'b1) done_q.push_back(cyc);
    if (frame_err === 1'b1) ferr_cnt++;
  end

  // Reference model: a byte lands at the next slot only while a load is armed
  bit model_armed = 1'b0;
  int model_ptr = 0;
  int exp_a[$], exp_v[$];
  int exp_done = 0;
  int exp_ferr = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic model_rx(input logic [7:0] b, input bit stop);
    bit good;
    good = stop || !CHECK;
    if (CHECK && !stop) exp_ferr++;
    if (model_armed && good) begin
      exp_a.push_back(model_ptr);
      exp_v.push_back(int'(b));
      model_ptr++;
      if (model_ptr == 4) begin
        exp_done++;
        model_armed = 1'b0;
        model_ptr   = 0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input bit stop);
    rx_data = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_data = b[i];
      tick(CPB);
    end
    rx_data = stop;
    tick(CPB);
    rx_data = 1'b1;
    if (!stop) tick(CPB);
    model_rx(b, stop);
  endtask

  task automatic arm();
    if (load_en) begin
      load_en = 1'b0;
      tick(4);
    end
    load_en = 1'b1;
    tick(4);
    model_armed = 1'b1;
    model_ptr   = 0;
  endtask

  task automatic disarm();
    load_en = 1'b0;
    tick(4);
    model_armed = 1'b0;
    model_ptr   = 0;
  endtask

  task automatic scoreboard(input string tag);
    int n;
    tick(6);
    chk({tag, "_nwrites"}, wa_q.size(), exp_a.size());
    n = (wa_q.size() < exp_a.size()) ? wa_q.size() : exp_a.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), wa_q[i], exp_a[i]);
      chk($sformatf("%s_val%0d", tag, i), wv_q[i], exp_v[i]);
    end
    chk({tag, "_wide_write"}, long_write, 0);
    chk({tag, "_ndone"}, done_q.size(), exp_done);
    if (done_q.size() == 1 && wc_q.size() > 0)
      chk({tag, "_done_lag"}, done_q[0] - wc_q[wc_q.size()-1], 2);
    chk({tag, "_nferr"}, ferr_cnt, exp_ferr);
    wa_q.delete(); wv_q.delete(); wc_q.delete(); done_q.delete();
    exp_a.delete(); exp_v.delete();
    exp_done = 0; exp_ferr = 0; long_write = 0; ferr_cnt = 0;
  endtask

  initial begin
    logic [7:0] b;

    // Reset values, during and after reset
    tick(3);
    chk("rst_write", write, 0);
    chk("rst_addr", write_address, 0);
    chk("rst_value", write_value, 0);
    chk("rst_count", values_recv_count, 0);
    chk("rst_led", state_LED, 5'b10000);
    chk("rst_done", load_done, 0);
    chk("rst_ferr", frame_err, 0);
    rst = 1'b1;
    tick(20);
    chk("idle_led", state_LED, 5'b10000);
    chk("idle_write", write, 0);
    scoreboard("idle");

    // Full load of four directed bytes
    arm();
    chk("arm_led", state_LED, 5'b01000);
    send(8'h11, 1'b1);
    chk("load_count1", values_recv_count, model_ptr);
    send(8'h22, 1'b1);
    chk("load_count2", values_recv_count, model_ptr);
    send(8'h33, 1'b1);
    chk("load_count3", values_recv_count, model_ptr);
    send(8'h44, 1'b1);
    chk("load_count_end", values_recv_count, 0);
    chk("load_led_end", state_LED, 5'b10000);
    scoreboard("load4");

    // Byte with load_en low is discarded
    disarm();
    send(8'hA5, 1'b1);
    chk("nold_count", values_recv_count, 0);
    scoreboard("noload");

    // Start-bit glitch, then a real byte
    arm();
    rx_data = 1'b0;
    tick(6);
    rx_data = 1'b1;
    tick(40);
    chk("glitch_led", state_LED, 5'b01000);
    chk("glitch_count", values_recv_count, 0);
    send(8'h5A, 1'b1);
    send(8'h66, 1'b1);
    chk("partial_count", values_recv_count, 2);
    disarm();
    chk("abort_led", state_LED, 5'b10000);
    chk("abort_count", values_recv_count, 0);
    arm();
    send(8'h77, 1'b1);
    disarm();
    scoreboard("glitch_abort");

    // Bad stop bit followed by a good byte
    arm();
    send(8'h3C, 1'b0);
    tick(10);
    send(8'h3D, 1'b1);
    disarm();
    scoreboard("framing");

    // Randomised loads, including back-to-back frames
    for (int r = 0; r < 3; r++) begin
      arm();
      for (int k = 0; k < 4; k++) begin
        if (r == 2 && k == 1) send(8'($urandom_range(0, 255)), 1'b0);
        b = 8'($urandom_range(0, 255));
        send(b, 1'b1);
        if (r == 0) begin
          chk($sformatf("rnd_count%0d", k), values_recv_count, model_ptr);
          chk($sformatf("rnd_led%0d", k), state_LED,
              model_armed ? 5'b01000 : 5'b10000);
        end else begin
          tick($urandom_range(0, 20));
        end
      end
      if (CHECK && r == 2) send(8'($urandom_range(0, 255)), 1'b1);
      scoreboard($sformatf("rnd_load%0d", r));
      disarm();
      send(8'($urandom_range(0, 255)), 1'b1);
      scoreboard($sformatf("rnd_idle%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
